// File: rtl/data_memory_ctrl.sv
// Clocked single-port data memory with byte/half/word access, load extension,
// a req/ready handshake, a registered one-cycle response and optional post-reset clear.
module data_memory_ctrl #(
  parameter int ADDR_W         = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              resp_valid,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic {S_INIT, S_IDLE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt;
  logic [31:0]      mem [DEPTH];

  logic             accept_p0;
  logic             legal_p0;
  logic [IDX_W-1:0] idx_p0;
  logic [1:0]       lane_p0;
  logic [3:0]       be_p0;
  logic [31:0]      wd_p0;

  function automatic logic is_legal(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      2'b00:   is_legal = 1'b1;
      2'b01:   is_legal = ~lane[0];
      2'b10:   is_legal = (lane == 2'b00);
      default: is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      2'b00:   lane_mask = 4'b0001 << lane;
      2'b01:   lane_mask = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data so every enabled lane sees its byte.
  function automatic logic [31:0] place_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   place_wdata = {4{d[7:0]}};
      2'b01:   place_wdata = {2{d[15:0]}};
      default: place_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [1:0] sz,
                                           input logic [1:0] lane, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   load_fmt = {{24{sx & b[7]}}, b};
      2'b01:   load_fmt = {{16{sx & h[15]}}, h};
      default: load_fmt = word;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= CLEAR_ON_RESET ? S_INIT : S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)              cnt <= '0;
    else if (state == S_INIT) cnt <= cnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    if (state == S_INIT && cnt == IDX_W'(DEPTH - 1)) state_nxt = S_IDLE;
  end

  // Gating with rst_n keeps ready low while reset is held, even when no clear runs.
  always_comb begin
    ready = rst_n && (state == S_IDLE);
  end

  assign accept_p0 = req & ready;
  assign lane_p0   = addr[1:0];
  assign idx_p0    = addr[ADDR_W-1:2];
  assign legal_p0  = is_legal(size, lane_p0);
  assign be_p0     = lane_mask(size, lane_p0);
  assign wd_p0     = place_wdata(size, wdata);

  always_ff @(posedge clk) begin
    if (rst_n && state == S_INIT) begin
      mem[cnt] <= '0;
    end else if (accept_p0 && we && legal_p0) begin
      for (int i = 0; i < 4; i++)
        if (be_p0[i]) mem[idx_p0][8*i +: 8] <= wd_p0[8*i +: 8];
    end
  end

  // Response stage: result registered at the accepting edge, visible the next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
    end else begin
      resp_valid <= accept_p0;
      err        <= accept_p0 & ~legal_p0;
      if (accept_p0)
        rdata <= (!we && legal_p0) ? load_fmt(mem[idx_p0], size, lane_p0, sign_ext) : 32'h0;
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Randomized self-checking bench for data_memory_ctrl against a byte-addressed reference model.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [31:0] wdata = 32'h0;
  logic        ready;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [7:0] mdl [256];

  data_memory_ctrl #(.ADDR_W(8), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .ready(ready), .resp_valid(resp_valid), .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: memory is a flat byte array; an access touches 1<<size consecutive bytes.
  task automatic model_access(input logic w, input logic [1:0] sz, input logic sx,
                              input logic [7:0] a, input logic [31:0] d,
                              output logic [31:0] exp_rd, output logic exp_err);
    int n;
    logic [31:0] val;
    bit legal;
    n = 1 << sz;
    legal = (sz != 2'd3) && (int'(a) % n == 0);
    exp_rd = 32'h0;
    exp_err = !legal;
    if (legal && w) begin
      for (int i = 0; i < n; i++) mdl[int'(a) + i] = d[8*i +: 8];
    end else if (legal) begin
      val = 32'h0;
      for (int i = 0; i < n; i++) val = val | (32'(mdl[int'(a) + i]) << (8*i));
      if (sx && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
      exp_rd = val;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
  endtask

  // One isolated request: accept edge, then one idle cycle to see the pulse drop.
  task automatic xfer(input logic w, input logic [1:0] sz, input logic sx,
                      input logic [7:0] a, input logic [31:0] d,
                      output logic rdy, output logic rv1, output logic [31:0] rd,
                      output logic e, output logic rv2);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    #1 rdy = ready;
    @(posedge clk); #1;
    rv1 = resp_valid; rd = rdata; e = err;
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    rv2 = resp_valid;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      n++;
      if (ready === 1'b1) begin seen = 1; break; end
    end
    checks++;
    if (!seen || n != 64) begin
      $display("FAIL %s: ready low for %0d cycles (rose=%0d), required 64", name, n, seen);
      errors++;
    end
  endtask

  task automatic test_reset();
    logic rdy, rv1, rv2, e, ee;
    logic [31:0] rd, erd;
    logic [7:0] al [3] = '{8'h00, 8'h7C, 8'hFC};
    @(negedge clk); rst_n = 1'b0; req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ready, resp_valid, err, rdata} !== 35'h0) begin
      $display("FAIL reset_outputs: got rdy=%b rv=%b err=%b rdata=%h, required all 0",
               ready, resp_valid, err, rdata);
      errors++;
    end
    @(negedge clk); rst_n = 1'b1;
    wait_ready("clear_length");
    model_clear();
    foreach (al[i]) begin
      model_access(1'b0, 2'd2, 1'b0, al[i], 32'h0, erd, ee);
      xfer(1'b0, 2'd2, 1'b0, al[i], 32'h0, rdy, rv1, rd, e, rv2);
      checks++;
      if (rd !== erd || e !== ee || rv1 !== 1'b1) begin
        $display("FAIL clear_read@%h: rdata=%h err=%b rv=%b, required %h %b 1",
                 al[i], rd, e, rv1, erd, ee);
        errors++;
      end
    end
  endtask

  task automatic test_store_lanes();
    logic rdy, rv1, rv2, e, ee;
    logic [31:0] rd, erd;
    logic        tw [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0]  ts [4] = '{2'd2, 2'd0, 2'd1, 2'd2};
    logic [7:0]  ta [4] = '{8'h10, 8'h11, 8'h12, 8'h10};
    logic [31:0] td [4] = '{32'h11223344, 32'h000000AA, 32'h0000BEEF, 32'h0};
    for (int i = 0; i < 4; i++) begin
      model_access(tw[i], ts[i], 1'b0, ta[i], td[i], erd, ee);
      xfer(tw[i], ts[i], 1'b0, ta[i], td[i], rdy, rv1, rd, e, rv2);
      checks++;
      if (rdy !== 1'b1 || rv1 !== 1'b1 || rv2 !== 1'b0) begin
        $display("FAIL lanes_handshake%0d: ready=%b rv=%b,%b required 1 1,0", i, rdy, rv1, rv2);
        errors++;
      end
      checks++;
      if (rd !== erd || e !== ee) begin
        $display("FAIL lanes_data%0d: rdata=%h err=%b required %h %b", i, rd, e, erd, ee);
        errors++;
      end
    end
    checks++;
    if (rd !== 32'hBEEFAA44) begin
      $display("FAIL lanes_merged: rdata=%h required BEEFAA44", rd);
      errors++;
    end
  endtask

  task automatic test_load_ext();
    logic rdy, rv1, rv2, e, ee;
    logic [31:0] rd, erd;
    logic [1:0]  ts [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic        tx [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] tk [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFF080, 32'h0000F080};
    model_access(1'b1, 2'd2, 1'b0, 8'h20, 32'h0000F080, erd, ee);
    xfer(1'b1, 2'd2, 1'b0, 8'h20, 32'h0000F080, rdy, rv1, rd, e, rv2);
    for (int i = 0; i < 4; i++) begin
      model_access(1'b0, ts[i], tx[i], 8'h20, 32'h0, erd, ee);
      xfer(1'b0, ts[i], tx[i], 8'h20, 32'h0, rdy, rv1, rd, e, rv2);
      checks++;
      if (rd !== erd || rd !== tk[i] || e !== 1'b0) begin
        $display("FAIL load_ext%0d: rdata=%h err=%b required %h 0", i, rd, e, tk[i]);
        errors++;
      end
    end
  endtask

  task automatic test_misaligned();
    logic rdy, rv1, rv2, e, ee;
    logic [31:0] rd, erd;
    logic        tw [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0]  ts [3] = '{2'd2, 2'd1, 2'd3};
    logic [7:0]  ta [3] = '{8'h41, 8'h23, 8'h24};
    model_access(1'b1, 2'd2, 1'b0, 8'h40, 32'h5A5A0F0F, erd, ee);
    xfer(1'b1, 2'd2, 1'b0, 8'h40, 32'h5A5A0F0F, rdy, rv1, rd, e, rv2);
    for (int i = 0; i < 3; i++) begin
      model_access(tw[i], ts[i], 1'b0, ta[i], 32'hDEADBEEF, erd, ee);
      xfer(tw[i], ts[i], 1'b0, ta[i], 32'hDEADBEEF, rdy, rv1, rd, e, rv2);
      checks++;
      if (e !== 1'b1 || rd !== 32'h0 || rv1 !== 1'b1 || ee !== 1'b1) begin
        $display("FAIL misalign%0d: err=%b rdata=%h rv=%b required 1 00000000 1", i, e, rd, rv1);
        errors++;
      end
      checks++;
      if (err !== 1'b0) begin
        $display("FAIL err_drop%0d: err=%b one cycle later, required 0", i, err);
        errors++;
      end
    end
    model_access(1'b0, 2'd2, 1'b0, 8'h40, 32'h0, erd, ee);
    xfer(1'b0, 2'd2, 1'b0, 8'h40, 32'h0, rdy, rv1, rd, e, rv2);
    checks++;
    if (rd !== erd || e !== 1'b0) begin
      $display("FAIL misalign_untouched: rdata=%h err=%b required %h 0", rd, e, erd);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] erd, erd2;
    logic ee, ee2, rv_a, rv_b, rv_c;
    logic [31:0] rd_b;
    model_access(1'b1, 2'd2, 1'b0, 8'h30, 32'h12345678, erd, ee);
    model_access(1'b0, 2'd2, 1'b0, 8'h30, 32'h0, erd2, ee2);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; sign_ext = 1'b0; addr = 8'h30; wdata = 32'h12345678;
    @(posedge clk); #1 rv_a = resp_valid;
    @(negedge clk); we = 1'b0;
    @(posedge clk); #1 rv_b = resp_valid; rd_b = rdata;
    @(negedge clk); req = 1'b0;
    @(posedge clk); #1 rv_c = resp_valid;
    checks++;
    if ({rv_a, rv_b, rv_c} !== 3'b110) begin
      $display("FAIL b2b_valid: pattern=%b required 110", {rv_a, rv_b, rv_c});
      errors++;
    end
    checks++;
    if (rd_b !== erd2 || rd_b !== 32'h12345678) begin
      $display("FAIL b2b_raw: rdata=%h required 12345678", rd_b);
      errors++;
    end
    // Random burst with req held high, confined to a small window to force RAW hazards.
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      logic w, sx;
      logic [1:0] sz;
      logic [7:0] a;
      logic [31:0] d;
      w = 1'($urandom); sx = 1'($urandom); sz = 2'($urandom_range(0, 3));
      a = 8'h80 + 8'($urandom_range(0, 15)); d = $urandom;
      req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
      model_access(w, sz, sx, a, d, erd, ee);
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || rdata !== erd || err !== ee) begin
        $display("FAIL burst%0d: rv=%b rdata=%h err=%b required 1 %h %b", i, resp_valid, rdata, err, erd, ee);
        errors++;
      end
      @(negedge clk);
    end
    req = 1'b0;
  endtask

  task automatic test_random();
    logic rdy, rv1, rv2, e, ee;
    logic [31:0] rd, erd;
    for (int i = 0; i < 150; i++) begin
      logic w, sx;
      logic [1:0] sz;
      logic [7:0] a;
      logic [31:0] d;
      w = 1'($urandom); sx = 1'($urandom); sz = 2'($urandom_range(0, 3));
      a = 8'($urandom); d = $urandom;
      model_access(w, sz, sx, a, d, erd, ee);
      xfer(w, sz, sx, a, d, rdy, rv1, rd, e, rv2);
      checks++;
      if (rdy !== 1'b1 || rv1 !== 1'b1 || rv2 !== 1'b0 || rd !== erd || e !== ee) begin
        $display("FAIL rand%0d: rdy=%b rv=%b,%b rdata=%h err=%b required 1 1,0 %h %b",
                 i, rdy, rv1, rv2, rd, e, erd, ee);
        errors++;
      end
    end
  endtask

  task automatic test_reset_mid_init();
    logic rdy, rv1, rv2, e, ee;
    logic [31:0] rd, erd;
    model_access(1'b1, 2'd2, 1'b0, 8'h50, 32'hCAFEF00D, erd, ee);
    xfer(1'b1, 2'd2, 1'b0, 8'h50, 32'hCAFEF00D, rdy, rv1, rd, e, rv2);
    // Load accepted, then reset on the following edge wipes the response.
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'd2; addr = 8'h50;
    @(posedge clk); #1 rv1 = resp_valid;
    @(negedge clk); req = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rv1 !== 1'b1 || resp_valid !== 1'b0 || rdata !== 32'h0 || ready !== 1'b0) begin
      $display("FAIL reset_kills_resp: rv=%b->%b rdata=%h ready=%b required 1->0 0 0",
               rv1, resp_valid, rdata, ready);
      errors++;
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    wait_ready("clear_restart");
    model_clear();
    model_access(1'b0, 2'd2, 1'b0, 8'h50, 32'h0, erd, ee);
    xfer(1'b0, 2'd2, 1'b0, 8'h50, 32'h0, rdy, rv1, rd, e, rv2);
    checks++;
    if (rd !== erd || rd !== 32'h0) begin
      $display("FAIL restart_cleared: rdata=%h required 00000000", rd);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_store_lanes();
    test_load_ext();
    test_misaligned();
    test_back_to_back();
    test_random();
    test_reset_mid_init();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
